// File: rtl/sw_debounce.sv
// Per-channel switch conditioner: 2-flop synchroniser, stability counter,
// accepted level register and registered single-cycle rise/fall pulses.
module sw_debounce #(
    parameter int unsigned p_WIDTH         = 4,
    parameter int unsigned p_STABLE_CYCLES = 250000,
    parameter int unsigned p_CNT_WIDTH     = $clog2(p_STABLE_CYCLES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [p_WIDTH-1:0] i_sw,
    output logic [p_WIDTH-1:0] o_level,
    output logic [p_WIDTH-1:0] o_rise,
    output logic [p_WIDTH-1:0] o_fall,
    output logic               o_settled
);

    localparam logic [p_CNT_WIDTH-1:0] lp_CNT_MAX = p_CNT_WIDTH'(p_STABLE_CYCLES - 1);
    localparam logic [p_CNT_WIDTH-1:0] lp_CNT_ONE = p_CNT_WIDTH'(1);

    logic [p_WIDTH-1:0]     sync1_q, sync1_d;
    logic [p_WIDTH-1:0]     sync2_q, sync2_d;
    logic [p_WIDTH-1:0]     level_q, level_d;
    logic [p_WIDTH-1:0]     rise_q,  rise_d;
    logic [p_WIDTH-1:0]     fall_q,  fall_d;
    logic [p_CNT_WIDTH-1:0] cnt_q [p_WIDTH];
    logic [p_CNT_WIDTH-1:0] cnt_d [p_WIDTH];

    always_comb begin
        sync1_d = i_sw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned n = 0; n < p_WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            // Any sample matching the accepted level restarts the stability count.
            if (sync2_q[n] == level_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == lp_CNT_MAX) begin
                level_d[n] = sync2_q[n];
                cnt_d[n]   = '0;
                rise_d[n]  = sync2_q[n];
                fall_d[n]  = ~sync2_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + lp_CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level   = level_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_settled = (sync2_q == level_q);

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and randomised checks of sw_debounce with a 4-cycle stability window,
// plus a second instance exercising the single-cycle window.
module tb_sw_debounce;

    localparam int unsigned W  = 4;
    localparam int unsigned SC = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] sw    = '0;
    logic [W-1:0] level, rise, fall;
    logic         settled;
    logic [W-1:0] sw1   = '0;
    logic [W-1:0] level1, rise1, fall1;
    logic         settled1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    sw_debounce #(.p_WIDTH(W), .p_STABLE_CYCLES(SC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw),
        .o_level(level), .o_rise(rise), .o_fall(fall), .o_settled(settled)
    );

    sw_debounce #(.p_WIDTH(W), .p_STABLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw1),
        .o_level(level1), .o_rise(rise1), .o_fall(fall1), .o_settled(settled1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        exp_v = {4'b0000, 4'b0000, 4'b0000, 1'b1};
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({level, rise, fall, settled} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_async: got %b required %b", {level, rise, fall, settled}, exp_v);
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_cmp++;
            if ({level, rise, fall, settled} !== exp_v) begin
                n_bad++;
                $display("FAIL reset_idle edge %0d: got %b required %b", e, {level, rise, fall, settled}, exp_v);
            end
        end
    endtask

    task automatic test_stable_one();
        logic [W-1:0] exp_l, exp_r, exp_f;
        logic         exp_s;
        sw1 = 4'b0011;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp_l = (e >= 3) ? 4'b0011 : 4'b0000;
            exp_r = (e == 3) ? 4'b0011 : 4'b0000;
            exp_s = (e == 2) ? 1'b0 : 1'b1;
            n_cmp++;
            if ({level1, rise1, fall1, settled1} !== {exp_l, exp_r, 4'b0000, exp_s}) begin
                n_bad++;
                $display("FAIL stable_one_rise edge %0d: got %b required %b", e,
                         {level1, rise1, fall1, settled1}, {exp_l, exp_r, 4'b0000, exp_s});
            end
        end
        sw1 = 4'b0001;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp_l = (e >= 3) ? 4'b0001 : 4'b0011;
            exp_f = (e == 3) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({level1, rise1, fall1} !== {exp_l, 4'b0000, exp_f}) begin
                n_bad++;
                $display("FAIL stable_one_fall edge %0d: got %b required %b", e,
                         {level1, rise1, fall1}, {exp_l, 4'b0000, exp_f});
            end
        end
    endtask

    task automatic test_single_rise();
        logic [W-1:0] exp_l, exp_r;
        logic         exp_s;
        sw = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_l = (e >= 6) ? 4'b0001 : 4'b0000;
            exp_r = (e == 6) ? 4'b0001 : 4'b0000;
            exp_s = (e >= 2 && e <= 5) ? 1'b0 : 1'b1;
            n_cmp++;
            if (level !== exp_l) begin
                n_bad++;
                $display("FAIL single_level edge %0d: got %b required %b", e, level, exp_l);
            end
            n_cmp++;
            if ({rise, fall} !== {exp_r, 4'b0000}) begin
                n_bad++;
                $display("FAIL single_pulse edge %0d: got %b required %b", e, {rise, fall}, {exp_r, 4'b0000});
            end
            n_cmp++;
            if (settled !== exp_s) begin
                n_bad++;
                $display("FAIL single_settled edge %0d: got %b required %b", e, settled, exp_s);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0]   pat;
        logic [W-1:0] exp_l, exp_r;
        pat = 5'b10101;
        for (int e = 1; e <= 14; e++) begin
            sw[1] = (e <= 5) ? pat[e-1] : 1'b1;
            step();
            exp_l = (e >= 10) ? 4'b0011 : 4'b0001;
            exp_r = (e == 10) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({level, rise, fall} !== {exp_l, exp_r, 4'b0000}) begin
                n_bad++;
                $display("FAIL bounce edge %0d: got %b required %b", e, {level, rise, fall}, {exp_l, exp_r, 4'b0000});
            end
        end
    endtask

    task automatic test_all_channels();
        logic [W-1:0] exp_l, exp_r, exp_f;
        sw = 4'b0000;
        repeat (8) step();
        n_cmp++;
        if (level !== 4'b0000) begin
            n_bad++;
            $display("FAIL all_clear: got %b required %b", level, 4'b0000);
        end
        sw = 4'b1111;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_l = (e >= 6) ? 4'b1111 : 4'b0000;
            exp_r = (e == 6) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if ({level, rise, fall} !== {exp_l, exp_r, 4'b0000}) begin
                n_bad++;
                $display("FAIL all_rise edge %0d: got %b required %b", e, {level, rise, fall}, {exp_l, exp_r, 4'b0000});
            end
        end
        sw = 4'b0101;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_l = (e >= 6) ? 4'b0101 : 4'b1111;
            exp_f = (e == 6) ? 4'b1010 : 4'b0000;
            n_cmp++;
            if ({level, rise, fall} !== {exp_l, 4'b0000, exp_f}) begin
                n_bad++;
                $display("FAIL all_fall edge %0d: got %b required %b", e, {level, rise, fall}, {exp_l, 4'b0000, exp_f});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_l, exp_r;
        logic         exp_s;
        sw = 4'b1111;
        repeat (8) step();
        n_cmp++;
        if (level !== 4'b1111) begin
            n_bad++;
            $display("FAIL mid_preset: got %b required %b", level, 4'b1111);
        end
        sw = 4'b0100;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({level, rise, fall, settled} !== {4'b0000, 4'b0000, 4'b0000, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_clear: got %b required %b", {level, rise, fall, settled},
                     {4'b0000, 4'b0000, 4'b0000, 1'b1});
        end
        #4;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_l = (e >= 6) ? 4'b0100 : 4'b0000;
            exp_r = (e == 6) ? 4'b0100 : 4'b0000;
            exp_s = (e >= 2 && e <= 5) ? 1'b0 : 1'b1;
            n_cmp++;
            if ({level, rise, fall, settled} !== {exp_l, exp_r, 4'b0000, exp_s}) begin
                n_bad++;
                $display("FAIL mid_release edge %0d: got %b required %b", e,
                         {level, rise, fall, settled}, {exp_l, exp_r, 4'b0000, exp_s});
            end
        end
    endtask

    task automatic test_soak();
        logic [W-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
        logic [W-1:0] m_win [4];
        logic         all_diff;
        int unsigned  r;
        rst_n = 1'b0;
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < 4; i++) m_win[i] = '0;
        #4;
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 7);
            if (r == 0) sw = 4'($urandom_range(0, 15));
            else if (r == 1) sw = sw ^ (4'b0001 << $urandom_range(0, 3));
            @(posedge clk);
            // A level is accepted once the last SC synchronised samples all oppose it.
            m_win[3] = m_win[2];
            m_win[2] = m_win[1];
            m_win[1] = m_win[0];
            m_win[0] = m_s2;
            m_rise = '0;
            m_fall = '0;
            for (int n = 0; n < W; n++) begin
                all_diff = (m_win[0][n] != m_lvl[n]) && (m_win[1][n] != m_lvl[n]) &&
                           (m_win[2][n] != m_lvl[n]) && (m_win[3][n] != m_lvl[n]);
                if (all_diff) begin
                    if (m_lvl[n]) m_fall[n] = 1'b1;
                    else          m_rise[n] = 1'b1;
                    m_lvl[n] = ~m_lvl[n];
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
            #1;
            n_cmp++;
            if ({level, rise, fall, settled} !== {m_lvl, m_rise, m_fall, (m_s2 == m_lvl)}) begin
                n_bad++;
                $display("FAIL soak cycle %0d: got %b required %b", c,
                         {level, rise, fall, settled}, {m_lvl, m_rise, m_fall, (m_s2 == m_lvl)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stable_one();
        test_single_rise();
        test_bounce();
        test_all_channels();
        test_reset_mid();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
